// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round/score sequencer: movement tick, hit scoring, pause, serve reload, winner.
// All outputs are decoded from registers only; hits and start are sampled on the clk edge.
module game_round_ctrl #(
  parameter int TICK_CYCLES = 500_000,
  parameter int PAUSE_TICKS = 100,
  parameter int WIN_SCORE   = 5,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit_p1,
  input  logic               hit_p2,
  output logic               tick_en,
  output logic               bullet_load,
  output logic               freeze,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         state,
  output logic [1:0]         winner
);

  localparam int CNT_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PAUSE_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PAUSE_W-1:0] r_pause_cnt;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic [1:0]         r_winner;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PAUSE_W-1:0] w_pause_nxt;
  logic [SCORE_W-1:0] w_score1_nxt;
  logic [SCORE_W-1:0] w_score2_nxt;
  logic [1:0]         w_winner_nxt;
  logic               w_raw_tick;
  logic [SCORE_W-1:0] w_s1_hit;
  logic [SCORE_W-1:0] w_s2_hit;
  logic               w_s1_win;
  logic               w_s2_win;

  assign w_raw_tick = (r_cnt == CNT_W'(TICK_CYCLES - 1));
  // Saturating add keeps scores from ever passing WIN_SCORE.
  assign w_s1_hit = (hit_p1 && (r_score1 != SCORE_W'(WIN_SCORE))) ? r_score1 + SCORE_W'(1) : r_score1;
  assign w_s2_hit = (hit_p2 && (r_score2 != SCORE_W'(WIN_SCORE))) ? r_score2 + SCORE_W'(1) : r_score2;
  assign w_s1_win = (w_s1_hit == SCORE_W'(WIN_SCORE));
  assign w_s2_win = (w_s2_hit == SCORE_W'(WIN_SCORE));

  // Holding cnt at 0 through SERVE aligns the first PLAY tick to a full period.
  assign w_cnt_nxt = ((r_state == S_SERVE) || w_raw_tick) ? '0 : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_pause_nxt  = r_pause_cnt;
    w_score1_nxt = r_score1;
    w_score2_nxt = r_score2;
    w_winner_nxt = r_winner;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_SERVE;
          w_score1_nxt = '0;
          w_score2_nxt = '0;
          w_winner_nxt = 2'b00;
        end
      end
      S_SERVE: w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (hit_p1 || hit_p2) begin
          w_score1_nxt = w_s1_hit;
          w_score2_nxt = w_s2_hit;
          if (w_s1_win || w_s2_win) begin
            w_state_nxt  = S_OVER;
            w_winner_nxt = {w_s2_win, w_s1_win};
          end else begin
            w_state_nxt = S_PAUSE;
            w_pause_nxt = '0;
          end
        end
      end
      S_PAUSE: begin
        if (w_raw_tick) begin
          if (r_pause_cnt == PAUSE_W'(PAUSE_TICKS - 1)) begin
            w_state_nxt = S_SERVE;
          end else begin
            w_pause_nxt = r_pause_cnt + PAUSE_W'(1);
          end
        end
      end
      S_OVER: begin
        if (start) begin
          w_state_nxt  = S_IDLE;
          w_score1_nxt = '0;
          w_score2_nxt = '0;
          w_winner_nxt = 2'b00;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pause_cnt <= '0;
      r_score1    <= '0;
      r_score2    <= '0;
      r_winner    <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pause_cnt <= w_pause_nxt;
      r_score1    <= w_score1_nxt;
      r_score2    <= w_score2_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  assign tick_en     = w_raw_tick && (r_state == S_PLAY);
  assign bullet_load = (r_state == S_SERVE);
  assign freeze      = (r_state != S_PLAY);
  assign score1      = r_score1;
  assign score2      = r_score2;
  assign state       = r_state;
  assign winner      = r_winner;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - bench for game_round_ctrl: vector table, corner sequences, random vs model.
module tb_game_round_ctrl;

  localparam int TICK  = 4;
  localparam int PAUSE = 2;
  localparam int WIN   = 3;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hit_p1 = 1'b0;
  logic          hit_p2 = 1'b0;
  logic          tick_en;
  logic          bullet_load;
  logic          freeze;
  logic [SW-1:0] score1;
  logic [SW-1:0] score2;
  logic [2:0]    state;
  logic [1:0]    winner;

  int total = 0;
  int bad   = 0;

  game_round_ctrl #(
    .TICK_CYCLES(TICK), .PAUSE_TICKS(PAUSE), .WIN_SCORE(WIN), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .tick_en(tick_en), .bullet_load(bullet_load), .freeze(freeze),
    .score1(score1), .score2(score2), .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  // Reference model: game mode, scores, position within the tick period, ticks spent paused.
  int m_mode, m_p1, m_p2, m_win, m_phase, m_paused;

  task automatic model_reset();
    m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_phase = 0; m_paused = 0;
  endtask

  task automatic model_step(input bit s, input bit h1, input bit h2);
    int old_mode;
    bit tick;
    old_mode = m_mode;
    tick = (m_phase == TICK - 1);
    case (m_mode)
      0: if (s) begin m_mode = 1; m_p1 = 0; m_p2 = 0; m_win = 0; end
      1: m_mode = 2;
      2: if (h1 || h2) begin
           if (h1 && m_p1 < WIN) m_p1++;
           if (h2 && m_p2 < WIN) m_p2++;
           if (m_p1 == WIN || m_p2 == WIN) begin
             m_mode = 4;
             m_win = (m_p1 == WIN ? 1 : 0) + (m_p2 == WIN ? 2 : 0);
           end else begin
             m_mode = 3; m_paused = 0;
           end
         end
      3: if (tick) begin
           m_paused++;
           if (m_paused == PAUSE) m_mode = 1;
         end
      default: if (s) begin m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; end
    endcase
    m_phase = (old_mode == 1) ? 0 : (m_phase + 1) % TICK;
  endtask

  function automatic logic [16:0] pack_dut();
    return {state, score1, score2, winner, tick_en, bullet_load, freeze};
  endfunction

  function automatic logic [16:0] pack_model();
    logic [2:0] st; logic [3:0] a, b; logic [1:0] w;
    st = 3'(m_mode); a = 4'(m_p1); b = 4'(m_p2); w = 2'(m_win);
    return {st, a, b, w, (m_phase == TICK - 1) && (m_mode == 2), m_mode == 1, m_mode != 2};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [16:0] g, e;
    g = pack_dut(); e = pack_model();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got st/s1/s2/win/tick/load/frz=%h expected %h at %0t", name, g, e, $time);
    end
  endtask

  task automatic step(input bit s, input bit h1, input bit h2);
    start = s; hit_p1 = h1; hit_p2 = h2;
    check_model("model");
    @(posedge clk);
    model_step(s, h1, h2);
    #1;
    start = 0; hit_p1 = 0; hit_p2 = 0;
  endtask

  task automatic run_until(input int mode, input string name);
    int n;
    n = 0;
    while (m_mode != mode && n < 60) begin step(0, 0, 0); n++; end
    if (m_mode != mode) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for state %0d, got %0d", name, mode, state);
    end
  endtask

  typedef struct {
    bit s, h1, h2;
    int st, s1, s2, w;
    bit tk, ld, fz;
  } vec_t;

  vec_t vt[15];

  initial begin
    //          s  h1 h2 st s1 s2 w  tk ld fz
    vt[0]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    vt[1]  = '{0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 2, 0, 0, 0, 1, 0, 0};
    vt[5]  = '{0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{1, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 1, 0, 3, 1, 0, 0, 0, 0, 1};
    vt[8]  = '{0, 0, 1, 3, 1, 0, 0, 0, 0, 1};
    vt[9]  = '{0, 0, 0, 3, 1, 0, 0, 0, 0, 1};
    vt[10] = '{0, 0, 0, 3, 1, 0, 0, 0, 0, 1};
    vt[11] = '{0, 0, 1, 3, 1, 0, 0, 0, 0, 1};
    vt[12] = '{0, 0, 0, 3, 1, 0, 0, 0, 0, 1};
    vt[13] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    vt[14] = '{0, 0, 0, 2, 1, 0, 0, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_scores", {score1, score2}, 0);
    chk("reset_winner", winner, 0);
    chk("reset_flags", {tick_en, bullet_load, freeze}, 3'b001);
    #2 rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      start = vt[i].s; hit_p1 = vt[i].h1; hit_p2 = vt[i].h2;
      @(posedge clk);
      model_step(vt[i].s, vt[i].h1, vt[i].h2);
      #1;
      start = 0; hit_p1 = 0; hit_p2 = 0;
      chk($sformatf("vec%0d_state", i), state, vt[i].st);
      chk($sformatf("vec%0d_scores", i), {score1, score2}, {4'(vt[i].s1), 4'(vt[i].s2)});
      chk($sformatf("vec%0d_winner", i), winner, vt[i].w);
      chk($sformatf("vec%0d_flags", i), {tick_en, bullet_load, freeze}, {vt[i].tk, vt[i].ld, vt[i].fz});
    end

    // Draw: bring scores to 2/2, then both hit on the same edge.
    step(0, 0, 1);
    run_until(2, "wait_play_a");
    step(0, 1, 1);
    chk("both_hit_22_scores", {score1, score2}, 8'h22);
    run_until(2, "wait_play_b");
    step(0, 1, 1);
    chk("draw_state", state, 4);
    chk("draw_scores", {score1, score2}, 8'h33);
    chk("draw_winner", winner, 2'b11);
    repeat (6) step(0, 1, 1);
    chk("over_hold_scores", {score1, score2}, 8'h33);
    step(1, 0, 0);
    chk("over_start_idle", {state, score1, score2, winner}, 0);

    // P2 wins with three separate hits.
    step(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      run_until(2, "wait_play_p2");
      step(0, 0, 1);
    end
    chk("p2_win_state", state, 4);
    chk("p2_win_winner", winner, 2'b10);
    chk("p2_win_scores", {score1, score2}, 8'h03);
    for (int k = 0; k < 2 * TICK; k++) begin
      step(0, 0, 0);
      chk("over_no_tick", tick_en, 0);
    end
    step(1, 0, 0);
    chk("p2_start_idle", {state, score1, score2, winner}, 0);

    // Asynchronous reset while paused.
    step(1, 0, 0);
    run_until(2, "wait_play_r");
    step(0, 1, 0);
    chk("pre_reset_pause", state, 3);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_state", state, 0);
    chk("async_rst_scores", {score1, score2}, 0);
    chk("async_rst_flags", {tick_en, bullet_load, freeze}, 3'b001);
    @(posedge clk);
    #3 rst_n = 1'b1;
    check_model("after_reset");

    // Randomized play against the reference model.
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(15) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0);
    end
    check_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
